// File: rtl/rf_pkg.sv
// Shared register-file constants and types for the write-back path.
package rf_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 1 << REG_AW;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Write-back requester slots on the arbiter
  localparam int unsigned WB_ALU = 0;
  localparam int unsigned WB_LSU = 1;
  localparam int unsigned WB_MDU = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned PW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PW-1:0]      gnt_idx,
  output logic               any
);

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    // Visit slots in priority order ptr, ptr+1, ... and take the first hit
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] && (i == (int'(ptr) + k) % NUM_REQ)) begin
          gnt[i]  = 1'b1;
          gnt_idx = PW'(i);
          any     = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter driving the register file's single write port.
// Define REGFILE_WB_SCOREBOARD_EN to build in the busy-register scoreboard.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = rf_pkg::XLEN,
  parameter int unsigned REG_AW  = rf_pkg::REG_AW
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_AW-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]   req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      RegWrite,
  output logic [REG_AW-1:0]         rd,
  output logic [XLEN-1:0]           WriteData,
  input  logic                      issue_valid,
  input  logic [REG_AW-1:0]         issue_rd,
  output logic [(1<<REG_AW)-1:0]    sb_busy
);

  import rf_pkg::*;

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gnt_idx;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] gnt;
  logic               any;
  logic [REG_AW-1:0]  sel_rd;
  logic [XLEN-1:0]    sel_data;

  // No grant is ever visible while reset is held
  assign req_masked = rst_n ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .PW     (PW)
  ) u_arb (
    .req    (req_masked),
    .ptr    (ptr),
    .gnt    (gnt),
    .gnt_idx(gnt_idx),
    .any    (any)
  );

  assign req_ready = gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd   = req_rd[i*REG_AW +: REG_AW];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      RegWrite  <= 1'b0;
      rd        <= '0;
      WriteData <= '0;
    end else if (any) begin
      ptr       <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
      RegWrite  <= |sel_rd;
      rd        <= sel_rd;
      WriteData <= sel_data;
    end else begin
      RegWrite  <= 1'b0;
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  logic [(1<<REG_AW)-1:0] sb_next;

  // Clear first so a same-cycle issue to the retiring register keeps it busy
  always_comb begin
    sb_next = sb_busy;
    if (any)
      sb_next[sel_rd] = 1'b0;
    if (issue_valid && (issue_rd != '0))
      sb_next[issue_rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sb_busy <= '0;
    else
      sb_busy <= sb_next;
  end
`else
  logic unused_issue;

  assign unused_issue = ^{issue_valid, issue_rd};
  assign sb_busy      = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus scoreboard queue.
module tb_regfile_wb_arbiter;

  import rf_pkg::*;

  localparam int N = 3;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N*REG_AW-1:0]   req_rd = '0;
  logic [N*XLEN-1:0]     req_data = '0;
  logic [N-1:0]          req_ready;
  logic                  RegWrite;
  reg_addr_t             rd;
  logic [XLEN-1:0]       WriteData;
  logic                  issue_valid = 1'b0;
  reg_addr_t             issue_rd = '0;
  logic [NUM_REGS-1:0]   sb_busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .NUM_REQ(N),
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .RegWrite   (RegWrite),
    .rd         (rd),
    .WriteData  (WriteData),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .sb_busy    (sb_busy)
  );

  typedef struct {
    logic            we;
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } exp_t;

  typedef struct {
    logic [N-1:0]        v;
    logic [N*REG_AW-1:0] r;
    logic [N*XLEN-1:0]   d;
    logic [N-1:0]        rdy;
  } vec_t;

  exp_t            q[$];
  vec_t            tbl[$];
  int              checks = 0;
  int              failures = 0;
  reg_addr_t       last_rd = '0;
  logic [XLEN-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [N-1:0] v, input int r2, input int r1, input int r0,
                              input logic [XLEN-1:0] d1, input logic [N-1:0] rdy);
    vec_t t;
    int   k;
    k     = tbl.size();
    t.v   = v;
    t.r   = {REG_AW'(r2), REG_AW'(r1), REG_AW'(r0)};
    t.d   = {32'h3000_0000 | XLEN'(k), d1, 32'h1000_0000 | XLEN'(k)};
    t.rdy = rdy;
    tbl.push_back(t);
  endfunction

  // Drive one cycle, check the grant, predict the write port and check it after the edge
  task automatic step(input logic [N-1:0] v, input logic [N*REG_AW-1:0] r,
                      input logic [N*XLEN-1:0] d, input logic [N-1:0] exp_rdy, input string nm);
    exp_t e;
    int   g;
    req_valid = v;
    req_rd    = r;
    req_data  = d;
    #1;
    chk({nm, " req_ready"}, 64'(req_ready), 64'(exp_rdy));
    g = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
    if (g >= 0) begin
      e.rd      = r[g*REG_AW +: REG_AW];
      e.data    = d[g*XLEN +: XLEN];
      e.we      = (e.rd != '0);
      last_rd   = e.rd;
      last_data = e.data;
    end else begin
      e.we   = 1'b0;
      e.rd   = last_rd;
      e.data = last_data;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({nm, " RegWrite"}, 64'(RegWrite), 64'(e.we));
    chk({nm, " rd"}, 64'(rd), 64'(e.rd));
    chk({nm, " WriteData"}, 64'(WriteData), 64'(e.data));
  endtask

  logic [NUM_REGS-1:0] sb7;
  logic [NUM_REGS-1:0] sb_exp;

  initial begin
    sb7 = '0;
    sb7[7] = 1'b1;

    // Reset state
    #2;
    chk("reset RegWrite", 64'(RegWrite), 64'd0);
    chk("reset rd", 64'(rd), 64'd0);
    chk("reset WriteData", 64'(WriteData), 64'd0);
    chk("reset sb_busy", 64'(sb_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a transfer
    step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hC0, 32'hB0, 32'hA0}, 3'b001, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset req_ready", 64'(req_ready), 64'd0);
    chk("midreset RegWrite", 64'(RegWrite), 64'd0);
    chk("midreset rd", 64'(rd), 64'd0);
    chk("midreset WriteData", 64'(WriteData), 64'd0);
    chk("midreset sb_busy", 64'(sb_busy), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    last_rd   = '0;
    last_data = '0;

    add(3'b111, 3, 2, 1, 32'h2000_0000, 3'b001);
    add(3'b000, 3, 2, 1, 32'h2000_0001, 3'b000);
    add(3'b010, 0, 5, 0, 32'hDEAD_BEEF, 3'b010);
    add(3'b000, 0, 5, 0, 32'hDEAD_BEEF, 3'b000);
    add(3'b100, 9, 0, 0, 32'h2000_0004, 3'b100);
    add(3'b111, 12, 11, 10, 32'h2000_0005, 3'b001);
    add(3'b111, 12, 11, 10, 32'h2000_0006, 3'b010);
    add(3'b111, 12, 11, 10, 32'h2000_0007, 3'b100);
    add(3'b111, 22, 21, 20, 32'h2000_0008, 3'b001);
    add(3'b111, 22, 21, 20, 32'h2000_0009, 3'b010);
    add(3'b111, 22, 21, 20, 32'h2000_000A, 3'b100);
    add(3'b001, 0, 0, 4, 32'h2000_000B, 3'b001);
    add(3'b100, 0, 0, 0, 32'h2000_000C, 3'b100);
    add(3'b111, 6, 7, 8, 32'h2000_000D, 3'b001);
    add(3'b010, 0, 13, 0, 32'h2000_000E, 3'b010);
    add(3'b010, 0, 14, 0, 32'h2000_000F, 3'b010);
    add(3'b011, 0, 15, 16, 32'h2000_0010, 3'b001);
    add(3'b101, 17, 0, 18, 32'h2000_0011, 3'b100);
    add(3'b000, 0, 0, 0, 32'h2000_0012, 3'b000);

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].v, tbl[i].r, tbl[i].d, tbl[i].rdy, $sformatf("vec%0d", i));

    // Scoreboard: set, clear, set-wins, x0 ignored
`ifdef REGFILE_WB_SCOREBOARD_EN
    sb_exp = sb7;
`else
    sb_exp = '0;
`endif
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    step(3'b000, '0, '0, 3'b000, "sb_issue");
    issue_valid = 1'b0;
    chk("sb_issue sb_busy", 64'(sb_busy), 64'(sb_exp));

    step(3'b010, REG_AW'(7) << (WB_LSU * REG_AW), 96'h0000_0000_7777_7777_0000_0000,
         3'b010, "sb_clear");
    chk("sb_clear sb_busy", 64'(sb_busy), 64'd0);

    issue_valid = 1'b1;
    step(3'b000, '0, '0, 3'b000, "sb_reissue");
    chk("sb_reissue sb_busy", 64'(sb_busy), 64'(sb_exp));

    step(3'b010, REG_AW'(7) << (WB_LSU * REG_AW), 96'h0000_0000_8888_8888_0000_0000,
         3'b010, "sb_setwins");
    chk("sb_setwins sb_busy", 64'(sb_busy), 64'(sb_exp));

    issue_rd = 5'd0;
    step(3'b000, '0, '0, 3'b000, "sb_x0");
    issue_valid = 1'b0;
    chk("sb_x0 sb_busy", 64'(sb_busy), 64'(sb_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32×32 register file. Up to `NUM_REQ` write-back sources (ALU, load unit, multiply/divide unit) compete for the register file's single write port. The block grants one source per cycle with round-robin priority and drives a registered write port (`RegWrite`/`rd`/`WriteData`). An optional busy-register scoreboard supports hazard detection in the issue stage.

## Interface
- `NUM_REQ`, default 3: number of write-back requesters, 2–8.
- `XLEN`, default 32: data width.
- `REG_AW`, default 5: register address width; 2^REG_AW registers.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: requester i holds a write.
- `req_rd` in NUM_REQ*REG_AW: destination of requester i, packed with i at LSB.
- `req_data` in NUM_REQ*XLEN: write data of requester i, packed.
- `req_ready` out NUM_REQ: one-hot grant; a transfer occurs when `req_valid[i] & req_ready[i]`.
- `RegWrite` out 1: register file write enable.
- `rd` out REG_AW: register file write address.
- `WriteData` out XLEN: register file write data.
- `issue_valid` in 1: an instruction with a destination is issued this cycle.
- `issue_rd` in REG_AW: destination of the issued instruction.
- `sb_busy` out 2^REG_AW: bit r set means register r has a write outstanding.

## Operation
- Arbitration is combinational from `req_valid` and the priority pointer `ptr`.
  - Scan starts at index `ptr` and goes upward modulo NUM_REQ.
  - The first valid requester receives `req_ready`.
  - No valid requesters means `req_ready` = 0.
  - `req_ready` never depends on `req_rd` or `req_data`.
- On a transfer from requester g:
  - At the next edge, `ptr` ← (g+1) mod NUM_REQ.
  - `RegWrite` ← (rd_g ≠ 0), `rd` ← rd_g, `WriteData` ← data_g.
  - A request to x0 is accepted and consumed but produces `RegWrite` = 0.
- No transfer: `RegWrite` ← 0; `rd`/`WriteData` hold their values; `ptr` holds.
- Requesters must hold `req_valid`, `req_rd` and `req_data` stable until accepted. The arbiter does not check this.
- Throughput is one write per cycle. No source waits more than NUM_REQ−1 grants.

## Timing
- Reset (async assert, sync release) sets `ptr` = 0, `RegWrite` = 0, `rd` = 0, `WriteData` = 0 and `sb_busy` = 0.
- `req_ready` is 0 while `rst_n` = 0.
- Latency is 1 cycle from the accept edge to `RegWrite` high. The register file samples it on the following edge.
- Back-to-back grants to different requesters are allowed. The same requester can win in consecutive cycles only when it is the sole valid requester.
- Reset asserted mid-operation discards any registered write. Requesters observe no grant.

## Configuration
- The macro `REGFILE_WB_SCOREBOARD_EN` compiles the scoreboard in or out.
- **Defined:**
  - `sb_busy[r]` is set at the edge where `issue_valid` is high and `issue_rd` = r ≠ 0.
  - `sb_busy[r]` is cleared at the edge where a transfer with rd_g = r is accepted.
  - If set and clear hit the same register in the same cycle, set wins.
  - Re-issuing to a register that is already busy leaves it busy. There is no counting.
  - `sb_busy[0]` is always 0.
- **Undefined:** `sb_busy` is tied to 0 and `issue_valid`/`issue_rd` are ignored. The port list is identical in both builds.

## Structure
- Shared package `rf_pkg`:
  - `REG_AW`, `XLEN` and `NUM_REGS` constants.
  - Type `reg_addr_t`.
  - Requester index constants `WB_ALU` = 0, `WB_LSU` = 1, `WB_MDU` = 2.
- One sub-module, `rr_arbiter`: a parameterised NUM_REQ round-robin picker.
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt`, encoded `gnt_idx`, `any`.
  - Purely combinational. The `ptr` register lives in the parent.
- The scoreboard is an `always` block in the parent, guarded by the macro.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-transfer with `req_valid` = 3'b111.
  - All outputs and `sb_busy` read 0 asynchronously.
  - After release, the first grant goes to requester 0.
- **Single requester:** only requester 1 valid, `rd` = 5, data 0xDEADBEEF.
  - `req_ready` = 3'b010 in the same cycle.
  - Next cycle: `RegWrite` = 1, `rd` = 5, `WriteData` = 0xDEADBEEF.
  - The cycle after, `RegWrite` = 0.
- **Round-robin:** all three requesters held valid for 6 cycles.
  - Grant order is 0,1,2,0,1,2.
  - `RegWrite` is high on 6 consecutive cycles, each with the matching rd and data.
- **x0 write:** requester 2 valid with `rd` = 0.
  - Accepted (`req_ready[2]` = 1).
  - Next cycle `RegWrite` = 0.
  - `ptr` advances to 0.
- **Scoreboard (macro defined):**
  - issue rd = 7 → `sb_busy[7]` = 1 next cycle.
  - LSU write to 7 accepted → `sb_busy[7]` = 0 next cycle.
  - Issue to 7 in the same cycle as an accepted write to 7 → `sb_busy[7]` stays 1.
- **Scoreboard (macro undefined):** issue rd = 7 → `sb_busy` stays 0.
